// File: rtl/alu_flagreg_seq.sv
// alu_flagreg_seq: registered flag ALU with persistent Z/C/N/V, carry-chained
// ADC/SBB, shifts, a WIDTH-cycle shift-add multiply and valid/ready on both sides.
module alu_flagreg_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             c,
  output logic             n,
  output logic             v,
  output logic             busy
);
  localparam int MSB = WIDTH - 1;
  localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4,  OP_NTA = 4'd5,  OP_NTB = 4'd6,  OP_ADC = 4'd7;
  localparam logic [3:0] OP_SBB = 4'd8,  OP_SHL = 4'd9,  OP_SHR = 4'd10, OP_ASR = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12, OP_PSA = 4'd13;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t               state, state_nxt;
  logic                 accept;
  logic                 mul_last;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   prod, prod_nxt;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c, alu_v;

  assign mul_last = (cnt == CW'(WIDTH - 1));

  // Handshake outputs and next state; a DONE-cycle accept is treated exactly like an IDLE accept.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    state_nxt = state;
    case (state)
      IDLE:    in_ready = 1'b1;
      MUL:     busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
    accept = in_valid && in_ready;
    if (accept)
      state_nxt = (opcode == OP_MUL) ? MUL : DONE;
    else if (state == MUL && mul_last)
      state_nxt = DONE;
    else if (state == DONE && out_ready)
      state_nxt = IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Single-cycle ops; c here is the stored carry of the last completed op.
  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (opcode)
      OP_ADD, OP_ADC: begin
        sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (opcode == OP_ADC) & c};
        alu_res = sum[MSB:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      OP_SUB, OP_SBB: begin
        // Borrow shows up as bit WIDTH of the WIDTH+1 bit difference.
        sum     = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (opcode == OP_SBB) & c};
        alu_res = sum[MSB:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NTA:  alu_res = ~a;
      OP_NTB:  alu_res = ~b;
      OP_PSA:  alu_res = a;
      OP_SHL: begin
        alu_res = {a[MSB-1:0], 1'b0};
        alu_c   = a[MSB];
      end
      OP_SHR: begin
        alu_res = {1'b0, a[MSB:1]};
        alu_c   = a[0];
      end
      OP_ASR: begin
        alu_res = {a[MSB], a[MSB:1]};
        alu_c   = a[0];
      end
      default: ;
    endcase
  end

  // One shift-add step: add multiplicand into the high half if the LSB is set, shift right.
  always_comb begin
    mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nxt = {mul_sum, prod[MSB:1]};
  end

  // Operand capture, multiply iteration, and flag/result load on completion only.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      z      <= 1'b0;
      c      <= 1'b0;
      n      <= 1'b0;
      v      <= 1'b0;
      prod   <= '0;
      mcand  <= '0;
      cnt    <= '0;
    end else if (accept) begin
      if (opcode == OP_MUL) begin
        mcand <= a;
        prod  <= {{WIDTH{1'b0}}, b};
        cnt   <= '0;
      end else begin
        result <= alu_res;
        z      <= (alu_res == '0);
        n      <= alu_res[MSB];
        c      <= alu_c;
        v      <= alu_v;
      end
    end else if (state == MUL) begin
      prod <= prod_nxt;
      cnt  <= cnt + 1'b1;
      if (mul_last) begin
        result <= prod_nxt[MSB:0];
        z      <= (prod_nxt[MSB:0] == '0);
        n      <= prod_nxt[MSB];
        c      <= |prod_nxt[2*WIDTH-1:WIDTH];
        v      <= |prod_nxt[2*WIDTH-1:WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_alu_flagreg_seq.sv
// tb_alu_flagreg_seq: directed vector table plus hand-written backpressure and reset sequences.
module tb_alu_flagreg_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] a, b;
  logic [3:0] opcode;
  logic       out_valid, out_ready;
  logic [7:0] result;
  logic       z, c, n, v, busy;

  int npass = 0;
  int ntot  = 0;

  alu_flagreg_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .z(z), .c(c), .n(n), .v(v), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z, c, n, v;
    int         lat;
  } vec_t;

  vec_t vt[24];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Drive one op from IDLE with out_ready=1 and check latency, busy/in_ready while waiting, outputs.
  task automatic run_op(input string nm, input logic [3:0] op, input logic [7:0] aa, input logic [7:0] bb,
                        input logic [7:0] er, input logic ez, input logic ec, input logic en,
                        input logic ev, input int el);
    int lat;
    bit side_ok;
    @(negedge clk);
    chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    opcode = op; a = aa; b = bb; in_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble operands after acceptance; they must already be captured.
    in_valid = 1'b0; a = ~aa; b = ~bb; opcode = 4'd14;
    lat = 1; side_ok = 1'b1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      if (!busy || in_ready) side_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(el));
    chk({nm, " busy/in_ready while waiting"}, 32'(side_ok), 32'd1);
    chk({nm, " {result,z,c,n,v}"}, 32'({result, z, c, n, v}), 32'({er, ez, ec, en, ev}));
  endtask

  initial begin
    bit ok;
    //         op     a      b      res    z     c     n     v     lat
    vt[0]  = '{4'd0,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    vt[1]  = '{4'd0,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    vt[2]  = '{4'd7,  8'h10, 8'h20, 8'h31, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vt[3]  = '{4'd1,  8'h05, 8'h07, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    vt[4]  = '{4'd8,  8'h05, 8'h01, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vt[5]  = '{4'd2,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vt[6]  = '{4'd3,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vt[7]  = '{4'd4,  8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vt[8]  = '{4'd5,  8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vt[9]  = '{4'd6,  8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vt[10] = '{4'd13, 8'h80, 8'h12, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vt[11] = '{4'd10, 8'h81, 8'h00, 8'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vt[12] = '{4'd9,  8'h40, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vt[13] = '{4'd11, 8'h80, 8'h00, 8'hC0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vt[14] = '{4'd14, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vt[15] = '{4'd1,  8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    vt[16] = '{4'd0,  8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1};
    vt[17] = '{4'd7,  8'h01, 8'h01, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vt[18] = '{4'd12, 8'h10, 8'h11, 8'h10, 1'b0, 1'b1, 1'b0, 1'b1, 9};
    vt[19] = '{4'd12, 8'h03, 8'h05, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 9};
    vt[20] = '{4'd12, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 9};
    vt[21] = '{4'd8,  8'h00, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    vt[22] = '{4'd15, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vt[23] = '{4'd7,  8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; opcode = '0;
    repeat (2) @(negedge clk);
    chk("reset state {out_valid,busy,in_ready,result,z,c,n,v}",
        32'({out_valid, busy, in_ready, result, z, c, n, v}), 32'({1'b0, 1'b0, 1'b1, 8'h00, 4'b0000}));
    rst = 1'b0;

    for (int i = 0; i < 24; i++)
      run_op($sformatf("vec%0d op%0d", i, vt[i].op), vt[i].op, vt[i].a, vt[i].b,
             vt[i].res, vt[i].z, vt[i].c, vt[i].n, vt[i].v, vt[i].lat);

    // Backpressure: ASR held for 5 cycles, then released together with a new SHL.
    @(negedge clk);
    out_ready = 1'b0; opcode = 4'd11; a = 8'h81; b = 8'h00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp ASR {out_valid,result,z,c,n,v}", 32'({out_valid, result, z, c, n, v}),
        32'({1'b1, 8'hC0, 1'b0, 1'b1, 1'b1, 1'b0}));
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      a = 8'(k); opcode = 4'(k);
      if (!out_valid || in_ready || result !== 8'hC0 || {z, c, n, v} !== 4'b0110) ok = 1'b0;
      @(negedge clk);
    end
    chk("bp hold stable", 32'(ok), 32'd1);
    out_ready = 1'b1; opcode = 4'd9; a = 8'h81; in_valid = 1'b1;
    #1;
    chk("bp in_ready follows out_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp SHL {out_valid,result,z,c,n,v}", 32'({out_valid, result, z, c, n, v}),
        32'({1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0}));

    // Reset in cycle 4 of a multiply aborts it.
    @(negedge clk);
    opcode = 4'd12; a = 8'h10; b = 8'h11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid-mul busy before reset", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("after reset {out_valid,busy,in_ready,result,z,c,n,v}",
        32'({out_valid, busy, in_ready, result, z, c, n, v}), 32'({1'b0, 1'b0, 1'b1, 8'h00, 4'b0000}));
    ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (out_valid || busy) ok = 1'b0;
      @(negedge clk);
    end
    chk("no output from aborted mul", 32'(ok), 32'd1);
    run_op("post-reset AND", 4'd2, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
